// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the 16K x 64-bit instruction memory and its fetch
// sequencer.
//   IMEM_ADDR_W   : line address width
//   IMEM_DATA_W   : line width (four 16-bit instructions)
//   IMEM_DEPTH    : number of lines
//   fetch_state_t : fetch sequencer state encoding
// -----------------------------------------------------------------------------
package imem_pkg;

  localparam int IMEM_ADDR_W = 14;
  localparam int IMEM_DATA_W = 64;
  localparam int IMEM_DEPTH  = 16384;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage : imem_pkg

// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
// Fetch sequencer for port A of the instruction memory. The memory registers
// its address on the clock edge and drives data combinationally from the
// latched address, so the pc register always mirrors that latched address
// while running.
//
// Ports:
//   clk            in   system clock (shared with memory port A)
//   rst            in   asynchronous, active-high reset
//   fetch_en       in   1 = fetch allowed
//   stall_in       in   decode cannot accept the current line
//   redirect_valid in   flush and restart fetch at redirect_addr
//   redirect_addr  in   redirect target line
//   mem_addr       out  memory port A address (combinational)
//   mem_data       in   memory port A read data
//   inst_line      out  line to decode (= mem_data)
//   inst_pc        out  line address of inst_line
//   inst_valid     out  inst_line is valid, correct-path data
//   line_count     out  number of lines consumed by decode
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not fetching; pc holds the next line to fetch
// RUN   | fetching; pc holds the address latched into memory (on mem_data)
// -----------------------------------------------------------------------------
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int                ADDR_W   = IMEM_ADDR_W,
  parameter int                DATA_W   = IMEM_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  input  logic              stall_in,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] inst_line,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  output logic [CNT_W-1:0]  line_count
);

  fetch_state_t      state_q;
  fetch_state_t      state_d;
  logic [ADDR_W-1:0] pc_q;
  logic [CNT_W-1:0]  line_count_q;
  logic              consume;

  // State register, pc and consumed-line counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      line_count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= mem_addr;
      if (consume) begin
        line_count_q <= line_count_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic. A stalled line is held until decode takes it, unless a
  // redirect discards it anyway.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fetch_en) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (!fetch_en && (!stall_in || redirect_valid)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic. mem_addr is forced to RESET_PC while reset is asserted so
  // the memory latches the reset line regardless of redirect inputs.
  always_comb begin
    mem_addr   = pc_q;
    inst_valid = 1'b0;
    consume    = 1'b0;
    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          mem_addr = redirect_addr;
        end
      end
      RUN: begin
        inst_valid = !redirect_valid;
        consume    = !redirect_valid && !stall_in;
        if (redirect_valid) begin
          mem_addr = redirect_addr;
        end else if (stall_in) begin
          mem_addr = pc_q;
        end else begin
          mem_addr = pc_q + ADDR_W'(1);
        end
      end
      default: begin
        mem_addr   = pc_q;
        inst_valid = 1'b0;
        consume    = 1'b0;
      end
    endcase
    if (rst) begin
      mem_addr = RESET_PC;
    end
  end

  assign inst_line  = mem_data;
  assign inst_pc    = pc_q;
  assign line_count = line_count_q;

endmodule : imem_fetch_ctrl
